de1_cl_lcd_timing: RTL

//  Raster timing generator and pixel output stage for the 480x272 cl LCD, clocked by the 9 MHz LCD clock.

---
 rtl/de1_cl_lcd_timing.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/de1_cl_lcd_timing.sv
// rtl/de1_cl_lcd_timing.sv - Raster timing, pixel request/output pipeline and PWM backlight for the 480x272 LCD
//
// Ports:
//   clk                  LCD pixel clock (9 MHz)
//   reset_n              async active-low reset (qualified by PLL lock upstream)
//   display_enable_in    1 = run raster, 0 = hold counters at 0 and drive idle pins
//   backlight_level      PWM duty in 1/256 steps
//   pixel_req/x/y        stage-0 request for one visible pixel
//   frame_start          one-cycle pulse with the request for pixel (0,0)
//   pixel_red/green/blue RGB for the previous cycle's request
//   lcd__*               panel pins: active-low syncs, DE, RGB, PWM backlight
//
// Pipeline: counters -> stage 0 (request, syncs) -> stage 1 (DE, syncs) -> pins.
// The RGB returned by the pixel source is registered with the pins, so sync,
// DE and RGB all leave the chip two cycles after the matching pixel_req.
module de1_cl_lcd_timing #(
  parameter int H_ACTIVE = 480,
  parameter int H_FRONT  = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       display_enable_in,
  input  logic [7:0] backlight_level,
  output logic       pixel_req,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  input  logic [5:0] pixel_red,
  input  logic [6:0] pixel_green,
  input  logic [5:0] pixel_blue,
  output logic       lcd__vsync_n,
  output logic       lcd__hsync_n,
  output logic       lcd__display_enable,
  output logic [5:0] lcd__red,
  output logic [6:0] lcd__green,
  output logic [5:0] lcd__blue,
  output logic       lcd__backlight
);

  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_active;
  logic       v_active;
  logic       h_in_sync;
  logic       v_in_sync;

  logic       s0_hsync_n;
  logic       s0_vsync_n;
  logic       s1_de;
  logic       s1_hsync_n;
  logic       s1_vsync_n;

  logic [7:0] bl_cnt;
  logic [7:0] bl_duty;

  assign h_active  = h_cnt < H_ACT;
  assign v_active  = v_cnt < V_ACT;
  assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Raster counters; disabling parks them at the origin so the next enabled
  // cycle is always pixel (0,0) of a fresh frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!display_enable_in) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Stage 0: pixel request to the framebuffer plus the syncs for this position.
  // pixel_x/pixel_y keep the last requested coordinate during blanking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_req   <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      s0_hsync_n  <= 1'b1;
      s0_vsync_n  <= 1'b1;
    end else if (!display_enable_in) begin
      pixel_req   <= 1'b0;
      frame_start <= 1'b0;
      s0_hsync_n  <= 1'b1;
      s0_vsync_n  <= 1'b1;
    end else begin
      pixel_req   <= h_active && v_active;
      if (h_active && v_active) begin
        pixel_x <= h_cnt;
        pixel_y <= v_cnt;
      end
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      s0_hsync_n  <= !h_in_sync;
      s0_vsync_n  <= !v_in_sync;
    end
  end

  // Stage 1 and pins. Dropping enable flushes the whole pipeline so the panel
  // sees idle levels on the very next cycle; the abandoned frame is not drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_de               <= 1'b0;
      s1_hsync_n          <= 1'b1;
      s1_vsync_n          <= 1'b1;
      lcd__display_enable <= 1'b0;
      lcd__hsync_n        <= 1'b1;
      lcd__vsync_n        <= 1'b1;
      lcd__red            <= '0;
      lcd__green          <= '0;
      lcd__blue           <= '0;
    end else if (!display_enable_in) begin
      s1_de               <= 1'b0;
      s1_hsync_n          <= 1'b1;
      s1_vsync_n          <= 1'b1;
      lcd__display_enable <= 1'b0;
      lcd__hsync_n        <= 1'b1;
      lcd__vsync_n        <= 1'b1;
      lcd__red            <= '0;
      lcd__green          <= '0;
      lcd__blue           <= '0;
    end else begin
      s1_de               <= pixel_req;
      s1_hsync_n          <= s0_hsync_n;
      s1_vsync_n          <= s0_vsync_n;
      lcd__display_enable <= s1_de;
      lcd__hsync_n        <= s1_hsync_n;
      lcd__vsync_n        <= s1_vsync_n;
      // Source data is only meaningful for requested pixels; blank otherwise.
      lcd__red            <= s1_de ? pixel_red   : 6'd0;
      lcd__green          <= s1_de ? pixel_green : 7'd0;
      lcd__blue           <= s1_de ? pixel_blue  : 6'd0;
    end
  end

  // Backlight PWM. The level is only taken at the end of a period, so a level
  // change never produces a runt pulse. Duty survives a disable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bl_cnt         <= '0;
      bl_duty        <= '0;
      lcd__backlight <= 1'b0;
    end else if (!display_enable_in) begin
      bl_cnt         <= '0;
      lcd__backlight <= 1'b0;
    end else begin
      bl_cnt         <= bl_cnt + 8'd1;
      if (bl_cnt == 8'hFF) begin
        bl_duty <= backlight_level;
      end
      lcd__backlight <= bl_cnt < bl_duty;
    end
  end

endmodule
